// File: rtl/addn_seq_if.sv
// Handshake and operand/result bundle for the multi-cycle adder addn_seq.
// The requester drives start and the operands; the adder returns busy/done and
// the registered result.
interface addn_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    // Requester side: issues operations and observes results.
    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    // Adder side: accepts operations and publishes results.
    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/addn_seq.sv
// Multi-cycle adder: computes A + B + Cin over WIDTH bits, CHUNK bits per clock.
// An operation is accepted in IDLE, then RUN adds one chunk per edge, least
// significant chunk first, rippling the carry through a register. On the last
// chunk the completed sum, carry-out and signed overflow are published together
// with a one-cycle done pulse. Every output comes straight from a flop.
// WIDTH must be a non-zero multiple of CHUNK.
module addn_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst,
    addn_seq_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Registered state
    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] part_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    // Next-state values
    state_t           state_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             carry_d;
    logic [WIDTH-1:0] part_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             busy_d;
    logic             done_d;

    // Chunk datapath
    int               base;
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK:0]   chunk_sum;

    // Select the current chunk of each operand and add it with the stored carry.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a value
        // at the top, so no path through the block can infer a latch.
        base      = int'(cnt_q) * CHUNK;
        a_k       = a_q[base +: CHUNK];
        b_k       = b_q[base +: CHUNK];
        chunk_sum = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state and output decode for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.Cin;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                part_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d               = chunk_sum[CHUNK];
                if (cnt_q == LAST_CHUNK) begin
                    // Publish the finished word; part_d already holds the top chunk.
                    sum_d   = part_d;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (part_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    // State register with synchronous reset that clears every flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled before the edge.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_addn_seq.sv
// Scoreboard bench for addn_seq. Three instances: 16/4 (directed and random),
// 4/1 (exhaustive) and 16/16 (random). Drivers push expected results with the
// cycle they must appear in; a monitor pops and compares on every done.
module tb_addn_seq;

    typedef struct {
        logic [16:0] res;   // {Cout, Sum}, zero-extended for narrow instances
        logic        ovf;
        longint      cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;
    int     overlap = 0;
    int     dbl = 0;
    logic   last_done16 = 1'b0;
    logic   last_done4  = 1'b0;
    logic   last_donew  = 1'b0;

    exp_t q16[$];
    exp_t q4[$];
    exp_t qw[$];

    addn_seq_if #(.WIDTH(16)) bus16 ();
    addn_seq_if #(.WIDTH(4))  bus4 ();
    addn_seq_if #(.WIDTH(16)) busw ();

    addn_seq #(.WIDTH(16), .CHUNK(4))  dut16 (.clk(clk), .rst(rst), .bus(bus16));
    addn_seq #(.WIDTH(4),  .CHUNK(1))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    addn_seq #(.WIDTH(16), .CHUNK(16)) dutw  (.clk(clk), .rst(rst), .bus(busw));

    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected results.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input int lat);
        exp_t e;
        e.res = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        e.ovf = (a[15] == b[15]) && (e.res[15] != a[15]);
        e.cyc = cyc + 1 + lat;
        return e;
    endfunction

    function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        exp_t e;
        logic [4:0] s;
        s     = {1'b0, a} + {1'b0, b} + {4'h0, cin};
        e.res = {12'h0, s};
        e.ovf = (a[3] == b[3]) && (s[3] != a[3]);
        e.cyc = cyc + 1 + 4;
        return e;
    endfunction

    // Wait (bounded) for the 16/4 adder to be idle, issue one operation and
    // optionally record its expected result.
    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [16:0] res, input logic ovf, input bit push);
        exp_t e;
        int   n = 0;
        while (bus16.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("d16_idle_timeout", bus16.busy, 0);
        bus16.A     = a;
        bus16.B     = b;
        bus16.Cin   = cin;
        bus16.start = 1'b1;
        e     = model16(a, b, cin, 4);
        e.res = res;
        e.ovf = ovf;
        if (push) q16.push_back(e);
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int n = 0;
        while (bus4.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("d4_idle_timeout", bus4.busy, 0);
        bus4.A     = a;
        bus4.B     = b;
        bus4.Cin   = cin;
        bus4.start = 1'b1;
        q4.push_back(model4(a, b, cin));
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic drivew(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int n = 0;
        while (busw.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("dw_idle_timeout", busw.busy, 0);
        busw.A     = a;
        busw.B     = b;
        busw.Cin   = cin;
        busw.start = 1'b1;
        qw.push_back(model16(a, b, cin, 1));
        @(negedge clk);
        busw.start = 1'b0;
    endtask

    // Monitor: compare every done against the scoreboard and track protocol rules.
    always @(negedge clk) begin
        exp_t e;
        if (bus16.done) begin
            if (q16.size() == 0) check("d16_spurious_done", bus16.done, 0);
            else begin
                e = q16.pop_front();
                check("d16_sum", {bus16.Cout, bus16.Sum}, e.res);
                check("d16_ovf", bus16.Ovf, e.ovf);
                check("d16_latency", cyc, e.cyc);
            end
        end
        if (bus4.done) begin
            if (q4.size() == 0) check("d4_spurious_done", bus4.done, 0);
            else begin
                e = q4.pop_front();
                check("d4_sum", {bus4.Cout, bus4.Sum}, e.res);
                check("d4_ovf", bus4.Ovf, e.ovf);
                check("d4_latency", cyc, e.cyc);
            end
        end
        if (busw.done) begin
            if (qw.size() == 0) check("dw_spurious_done", busw.done, 0);
            else begin
                e = qw.pop_front();
                check("dw_sum", {busw.Cout, busw.Sum}, e.res);
                check("dw_ovf", busw.Ovf, e.ovf);
                check("dw_latency", cyc, e.cyc);
            end
        end
        if ((bus16.busy && bus16.done) || (bus4.busy && bus4.done) || (busw.busy && busw.done))
            overlap++;
        if ((bus16.done && last_done16) || (bus4.done && last_done4) || (busw.done && last_donew))
            dbl++;
        last_done16 <= bus16.done;
        last_done4  <= bus4.done;
        last_donew  <= busw.done;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;

        rst = 1'b1;
        bus16.start = 1'b1; bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.Cin = 1'b1;
        bus4.start  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.Cin  = 1'b0;
        busw.start  = 1'b0; busw.A  = '0; busw.B  = '0; busw.Cin  = 1'b0;

        // Reset held two cycles with start high: nothing may start.
        repeat (2) @(negedge clk);
        check("rst_busy", bus16.busy, 0);
        check("rst_done", bus16.done, 0);
        check("rst_sum",  bus16.Sum, 16'h0000);
        check("rst_cout", bus16.Cout, 0);
        check("rst_ovf",  bus16.Ovf, 0);
        rst = 1'b0;
        bus16.start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", bus16.busy, 0);

        // Basic add, with busy width measured.
        drive16(16'h1234, 16'h1111, 1'b0, 17'h02345, 1'b0, 1'b1);
        n = 0;
        while (bus16.busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("basic_busy_cycles", n, 4);

        // Carry ripple and signed overflow corners.
        drive16(16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b0, 1'b1);
        drive16(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, 1'b1);
        drive16(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1, 1'b1);

        // Start while busy with new operands must be ignored.
        drive16(16'h0003, 16'h0004, 1'b0, 17'h00007, 1'b0, 1'b1);
        bus16.A = 16'hAAAA; bus16.B = 16'h5555; bus16.Cin = 1'b1;
        bus16.start = 1'b1;
        repeat (2) @(negedge clk);
        bus16.start = 1'b0;
        n = 0;
        while (bus16.busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        // Restart in the done cycle itself.
        check("b2b_in_done_cycle", bus16.done, 1);
        drive16(16'h0100, 16'h0200, 1'b0, 17'h00300, 1'b0, 1'b1);
        n = 0;
        while (bus16.busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);

        // Abort: reset sampled on the second RUN edge, no done may follow.
        drive16(16'h1111, 16'h2222, 1'b0, 17'h03333, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus16.busy, 0);
        check("abort_done", bus16.done, 0);
        check("abort_sum",  bus16.Sum, 16'h0000);
        check("abort_cout", bus16.Cout, 0);
        check("abort_ovf",  bus16.Ovf, 0);
        repeat (8) @(negedge clk);
        check("abort_still_idle", bus16.busy, 0);

        // Sweeps on all three configurations in parallel.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                    c = 1'($urandom);
                    drive16(a, b, c, model16(a, b, c, 4).res, model16(a, b, c, 4).ovf, 1'b1);
                end
            end
            begin
                logic [8:0] v;
                for (int i = 0; i < 512; i++) begin
                    v = 9'(i);
                    drive4(v[3:0], v[7:4], v[8]);
                end
            end
            begin
                logic [15:0] wa;
                logic [15:0] wb;
                logic        wc;
                for (int i = 0; i < 1000; i++) begin
                    wa = 16'($urandom);
                    wb = 16'($urandom);
                    wc = 1'($urandom);
                    drivew(wa, wb, wc);
                end
            end
        join

        repeat (20) @(negedge clk);
        check("d16_queue_drained", q16.size(), 0);
        check("d4_queue_drained",  q4.size(), 0);
        check("dw_queue_drained",  qw.size(), 0);
        check("busy_done_overlap", overlap, 0);
        check("done_back_to_back", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addn_seq.md
# addn_seq

Parametrised multi-cycle adder, the successor to the fixed 4-bit combinational adder. It computes A + B + Cin over WIDTH bits, CHUNK bits per clock. A start/busy/done handshake frames each operation, and the block reports carry-out and signed overflow. It trades latency for a short carry chain and sits wherever the datapath needs wide adds at high clock rates.

## Interface
Parameters:
- WIDTH, 16: operand and sum width in bits. Must be ≥ 1.
- CHUNK, 4: bits added per clock. WIDTH must be an exact multiple of CHUNK. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset. Dominates every other input.
- start  in  1  request a new operation. Sampled only while busy = 0.
- A  in  WIDTH  operand A. Captured on the accepting edge.
- B  in  WIDTH  operand B. Captured on the accepting edge.
- Cin  in  1  carry-in. Captured on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when Sum, Cout and Ovf are updated.
- Sum  out  WIDTH  result of the last completed operation.
- Cout  out  1  unsigned carry-out of the last completed operation.
- Ovf  out  1  two's-complement overflow of the last completed operation.

## Operation
- State machine: IDLE, RUN.
- IDLE:
  - start = 1 captures A, B and Cin into internal registers.
  - Clears the chunk counter and the internal carry (the carry register is loaded with Cin).
  - Moves to RUN. busy = 1.
- RUN, one chunk per edge:
  - Chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) = A_k + B_k + carry.
  - The chunk result is written into the internal partial-sum register, and its carry-out is stored for chunk k+1.
  - The counter increments.
- Last chunk (counter = NCHUNK-1):
  - On the same edge the completed partial sum is copied to Sum.
  - Cout takes the final carry.
  - Ovf = (A[WIDTH-1] == B[WIDTH-1]) && (Sum[WIDTH-1] != A[WIDTH-1]).
  - done pulses, busy drops and the state returns to IDLE.
- Sum, Cout and Ovf change only on the done edge. Between operations they hold their values.
- Arithmetic is modulo 2^WIDTH, and the {Cout, Sum} pair always equals A + B + Cin exactly.
- Operand changes on A, B or Cin after the accepting edge have no effect.
- start while busy = 1 is ignored, not queued.
- Reset behaviour:
  - rst = 1 forces state IDLE, busy = 0, done = 0, Sum = 0, Cout = 0, Ovf = 0, counter = 0 and clears all internal registers.
  - Reset mid-operation aborts the operation. No done pulse follows.
  - rst and start high on the same edge: reset wins, start is discarded.

## Timing
- Accepting edge E0 (start = 1, busy = 0, rst = 0).
- Latency: busy = 1 during cycles after E0 through E(NCHUNK). done = 1 for exactly one cycle after E(NCHUNK), concurrent with the new Sum, Cout and Ovf.
- Back-to-back: start may be high in the cycle where done = 1, because busy = 0 then. It is accepted, giving one result every NCHUNK+1 cycles.
- CHUNK = WIDTH (NCHUNK = 1): done follows E0 by one edge, and busy is high for one cycle.
- done never asserts two cycles in a row.
- busy and done are never both high.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
Defaults: WIDTH = 16, CHUNK = 4, so latency is 4 edges.
- Reset: hold rst for 2 cycles with start = 1 -> busy = 0, done = 0, Sum = 0x0000, Cout = 0, Ovf = 0. No operation starts.
- Basic add: A = 0x1234, B = 0x1111, Cin = 0 -> done 4 edges after E0, Sum = 0x2345, Cout = 0, Ovf = 0. busy high for exactly 4 cycles.
- Full carry ripple: A = 0xFFFF, B = 0x0000, Cin = 1 -> Sum = 0x0000, Cout = 1, Ovf = 0. Checks carry propagation across all chunks.
- Signed overflow:
  - A = 0x7FFF, B = 0x0001, Cin = 0 -> Sum = 0x8000, Cout = 0, Ovf = 1.
  - Then A = 0x8000, B = 0x8000 -> Sum = 0x0000, Cout = 1, Ovf = 1.
- Handshake robustness:
  - Start with A = 0x0003, B = 0x0004.
  - Then change the operands and pulse start while busy.
  - Required: the result is Sum = 0x0007, with no second done.
  - Start again in the done cycle: accepted, and its result appears 4 edges later.
- Abort and sweep:
  - Assert rst at the second RUN edge -> no done, all outputs 0.
  - Then run 1000 random operands plus all 2^9 combinations at WIDTH = 4, CHUNK = 1, and at WIDTH = CHUNK = 16.
  - Required: {Cout, Sum} = A + B + Cin at every done, with latency NCHUNK.
